// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the two producer streams, the FIFO write port and the debug outputs
// of the packet-atomic FIFO write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       s0_data;
    logic             s0_valid;
    logic             s0_last;
    logic             s0_ready;
    logic [7:0]       s1_data;
    logic             s1_valid;
    logic             s1_last;
    logic             s1_ready;
    logic [7:0]       fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full;
    logic [1:0]       grant;
    logic             len_err;
    logic [CNT_W-1:0] s0_pkts;
    logic [CNT_W-1:0] s1_pkts;

    // master: the arbiter itself
    modport master (
        input  s0_data, s0_valid, s0_last,
        input  s1_data, s1_valid, s1_last,
        input  fifo_full,
        output s0_ready, s1_ready,
        output fifo_din, fifo_wr_en,
        output grant, len_err, s0_pkts, s1_pkts
    );

    // slave: the producers, the FIFO and any debug observer
    modport slave (
        output s0_data, s0_valid, s0_last,
        output s1_data, s1_valid, s1_last,
        output fifo_full,
        input  s0_ready, s1_ready,
        input  fifo_din, fifo_wr_en,
        input  grant, len_err, s0_pkts, s1_pkts
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one byte-FIFO write port between two
// sources, with a packet length cap and saturating per-source packet counters.
module fifo_wr_arbiter #(
    parameter int MAX_PKT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    fifo_wr_arbiter_if.master    bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;
    localparam logic [7:0] BEAT_CAP = 8'(MAX_PKT - 1);

    logic [1:0]       state_reg, state_next;
    logic             rr_last_reg;
    logic [7:0]       beat_cnt_reg;
    logic             len_err_reg;

    logic [7:0]       src_data  [2];
    logic [1:0]       src_valid;
    logic [1:0]       src_last;
    logic [1:0]       src_ready;
    logic [CNT_W-1:0] pkts      [2];

    logic             active;
    logic             sel;
    logic             xfer;
    logic             eop;

    assign src_data[0] = bus.s0_data;
    assign src_data[1] = bus.s1_data;
    assign src_valid   = {bus.s1_valid, bus.s0_valid};
    assign src_last    = {bus.s1_last,  bus.s0_last};

    assign active = (state_reg == GRANT0) || (state_reg == GRANT1);
    assign sel    = (state_reg == GRANT1);
    assign xfer   = active && src_valid[sel] && !bus.fifo_full;
    // A packet closes on its own last byte or when the cap is reached.
    assign eop    = xfer && (src_last[sel] || (beat_cnt_reg == BEAT_CAP));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (src_valid[0] && src_valid[1]) begin
                    state_next = rr_last_reg ? GRANT0 : GRANT1;
                end else if (src_valid[0]) begin
                    state_next = GRANT0;
                end else if (src_valid[1]) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (eop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg    <= IDLE;
            rr_last_reg  <= 1'b1;
            beat_cnt_reg <= 8'd0;
            len_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (eop) begin
                beat_cnt_reg <= 8'd0;
                rr_last_reg  <= sel;
                if (!src_last[sel]) begin
                    len_err_reg <= 1'b1;
                end
            end else if (xfer) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_src
            localparam logic [1:0] OWN_STATE = (gi == 0) ? GRANT0 : GRANT1;
            logic [CNT_W-1:0] cnt_reg;

            assign src_ready[gi] = (state_reg == OWN_STATE) && !bus.fifo_full;
            assign pkts[gi]      = cnt_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    cnt_reg <= '0;
                end else if (eop && (sel == 1'(gi)) && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.s0_ready   = src_ready[0];
    assign bus.s1_ready   = src_ready[1];
    assign bus.fifo_wr_en = xfer;
    assign bus.fifo_din   = active ? src_data[sel] : 8'h00;
    assign bus.grant      = {state_reg == GRANT1, state_reg == GRANT0};
    assign bus.len_err    = len_err_reg;
    assign bus.s0_pkts    = pkts[0];
    assign bus.s1_pkts    = pkts[1];
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single 8-bit write port of the byte FIFO between two producer streams (s0, s1).
- Once a source is granted, its packet goes into the FIFO unbroken until its last byte.
- Sits directly in front of the FIFO's din/wr_en/full interface.
- Also enforces a maximum packet length and keeps per-source completed-packet counters for debug.

Parameters:
- MAX_PKT, 64: maximum bytes per packet. Range 1..255.
- CNT_W, 16: width of the per-source packet counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- srst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- s0_data  in  8  source 0 byte.
- s0_valid  in  1  source 0 byte valid.
- s0_last  in  1  source 0 byte is the final byte of its packet.
- s0_ready  out  1  source 0 byte accepted this cycle when high together with s0_valid.
- s1_data, s1_valid, s1_last, s1_ready: same as the s0 ports, for source 1.
- fifo_din  out  8  byte to the FIFO.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag.
- grant  out  2  one-hot current owner: 01 = s0, 10 = s1, 00 = idle.
- len_err  out  1  sticky: a packet was truncated at MAX_PKT.
- s0_pkts  out  CNT_W  s0 packets completed; saturating.
- s1_pkts  out  CNT_W  s1 packets completed; saturating.

Behaviour:
- State machine: IDLE, GRANT0, GRANT1. State is registered; grant is decoded from state.
- Reset (srst high at a posedge), from any state, including mid-packet:
  - state = IDLE, rr_last = 1 (so s0 wins the first contention).
  - beat_cnt = 0, len_err = 0, s0_pkts = 0, s1_pkts = 0.
  - A partially written packet is abandoned; the FIFO's own reset is handled separately.
- IDLE:
  - s0_ready = s1_ready = 0, fifo_wr_en = 0, fifo_din = 0.
  - Only s0_valid high: go to GRANT0. Only s1_valid high: go to GRANT1.
  - Both high: grant the source other than rr_last. Neither high: stay in IDLE.
  - Arbitration costs one cycle: no byte transfers in the cycle the decision is made.
- GRANTx, combinational outputs:
  - sx_ready = !fifo_full. The other source's ready = 0.
  - fifo_wr_en = sx_valid && !fifo_full.
  - fifo_din = sx_data.
  - No byte is ever presented while fifo_full = 1. Valid and data are held by the source.
- Transfer: a cycle with sx_valid && sx_ready.
  - Each transfer increments beat_cnt (8 bits).
- End of packet: a transfer with sx_last = 1, or a transfer where beat_cnt == MAX_PKT-1.
  - On that posedge: state goes to IDLE, rr_last = x, beat_cnt = 0, sx_pkts increments (saturates at all-ones).
  - If the packet ended on the length cap with sx_last = 0, len_err is set to 1 and stays set until srst.
  - After truncation, the remaining bytes of that packet are treated as a new packet and are re-arbitrated.
- Gaps: sx_valid low mid-packet keeps the grant (no timeout). fifo_full high mid-packet stalls in place; beat_cnt holds.
- Back-to-back packets from the same source with the other source idle: one IDLE bubble cycle between them.
- Latency: first byte is written 1 cycle after valid is seen in IDLE, then 1 byte/cycle while the FIFO is not full.
- Counters and len_err are registered; grant is glitch-free (decoded from registered state).

Test Plan:
- Reset, then s0 sends 3 bytes (0xA1, 0xA2, 0xA3; last on 0xA3) with the FIFO not full -> grant = 01 one cycle after valid; fifo_wr_en high for 3 consecutive cycles with din A1, A2, A3; then grant = 00; s0_pkts = 1.
- s0 and s1 both valid from reset, each sending 2-byte packets repeatedly -> packet order s0, s1, s0, s1; bytes never interleaved within a packet; each source's counter = 2 after 4 packets.
- fifo_full asserted for 5 cycles in the middle of a 4-byte s1 packet -> fifo_wr_en and s1_ready low for those 5 cycles; grant stays 10; the remaining bytes follow in order; no byte lost or duplicated.
- MAX_PKT = 4, s0 sends 6 bytes with last only on byte 6 -> return to IDLE after byte 4; len_err = 1; s0_pkts = 1 then 2 after bytes 5-6 complete.
- srst pulsed while in GRANT1 after 2 bytes of a packet -> next cycle grant = 00, all counters 0, len_err 0; with both valid, s0 is granted first.
- Drive s0 packet count to the CNT_W saturation value (use CNT_W = 4 in a second build) -> s0_pkts sticks at 15 after 16+ packets.
